// File: rtl/t07_spi_pkg.sv
// Shared types and frame (de)interleave helpers for the SPI TFT link.
// Used by t07_spi_frame_rx and the matching transmitter.
package t07_spi_pkg;

  localparam int FRAME_BITS_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_WAIT_CS = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } word_pair_t;

  // Frame byte order on the wire: A3 D3 A2 D2 A1 D1 A0 D0 (MSB first).
  function automatic word_pair_t deinterleave(input logic [63:0] f);
    word_pair_t p;
    p.addr = {f[63:56], f[47:40], f[31:24], f[15:8]};
    p.data = {f[55:48], f[39:32], f[23:16], f[7:0]};
    return p;
  endfunction

  function automatic logic [63:0] interleave(input logic [31:0] addr,
                                             input logic [31:0] data);
    return {addr[31:24], data[31:24], addr[23:16], data[23:16],
            addr[15:8],  data[15:8],  addr[7:0],   data[7:0]};
  endfunction

endpackage

// File: rtl/t07_sync_edge.sv
// N-stage synchroniser with rise/fall detection on the synchronised level.
module t07_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = ~prev_q &  sync_q[STAGES-1];
  assign fall_o =  prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/t07_spi_frame_rx.sv
// SPI target: receives interleaved address/data frames and offers them on valid/ready.
// Define T07_SPIRX_MISO_EN to echo the last accepted frame on miso_o.
module t07_spi_frame_rx
  import t07_spi_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cs_n_i,
  input  logic        sclk_i,
  input  logic        mosi_i,
  input  logic        ready_i,
  input  logic        clr_i,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        abort_o,
  output logic        overrun_o,
  output logic        miso_o
);

  localparam int CW = $clog2(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] cs_sync_q, mosi_sync_q;
  logic                   cs_s, mosi_s, sclk_rise, sclk_fall;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic                   done_q, done_d, abort_q, abort_d;
  logic [31:0]            addr_q, addr_d, data_q, data_d;
  logic                   valid_q, valid_d, ovr_q, ovr_d;
  logic [63:0]            frame64;
  word_pair_t             rx_pair;

  // cs_n idles high, so its stages reset to 1 to avoid a false frame start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    end
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  t07_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .nrst   (nrst),
    .d_i    (sclk_i),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cs_s) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_s) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(FRAME_BITS - 1)) begin
            done_d  = 1'b1;
            state_d = ST_WAIT_CS;
          end
        end
      end
      ST_WAIT_CS: begin
        if (cs_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shorter frames are left-aligned so the address byte is still first.
  if (FRAME_BITS >= 64) begin : g_wide
    assign frame64 = shift_q[63:0];
  end else begin : g_narrow
    assign frame64 = {shift_q, {(64 - FRAME_BITS){1'b0}}};
  end

  assign rx_pair = deinterleave(frame64);

  // done_q is one cycle behind the last shift, so shift_q already holds bit 64.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (clr_i) ovr_d = 1'b0;
    if (done_q) begin
      if (!valid_q || ready_i) begin
        addr_d  = rx_pair.addr;
        data_d  = rx_pair.data;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q == ST_SHIFT);
  assign abort_o   = abort_q;
  assign overrun_o = ovr_q;

`ifdef T07_SPIRX_MISO_EN
  logic        cs_prev_q;
  logic [63:0] tx_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cs_prev_q <= 1'b1;
      tx_q      <= '0;
    end else begin
      cs_prev_q <= cs_s;
      if (cs_prev_q && !cs_s) tx_q <= interleave(addr_q, data_q);
      else if (sclk_fall)     tx_q <= {tx_q[62:0], 1'b0};
    end
  end

  assign miso_o = tx_q[63];
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;
  assign miso_o = 1'b0;
`endif

endmodule

// File: tb/tb_t07_spi_frame_rx.sv
// Self-checking bench for t07_spi_frame_rx (echo test active with T07_SPIRX_MISO_EN).
module tb_t07_spi_frame_rx;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cs_n_i = 1'b1, sclk_i = 1'b0, mosi_i = 1'b0;
  logic        ready_i = 1'b0, clr_i = 1'b0;
  logic [31:0] addr_o, data_o;
  logic        valid_o, busy_o, abort_o, overrun_o, miso_o;

  int          checks = 0;
  int          errors = 0;
  int          abort_cyc = 0;
  int          ovr_cyc = 0;
  bit          rand_ready = 1'b0;
  logic [63:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  t07_spi_frame_rx dut (
    .clk       (clk),
    .nrst      (nrst),
    .cs_n_i    (cs_n_i),
    .sclk_i    (sclk_i),
    .mosi_i    (mosi_i),
    .ready_i   (ready_i),
    .clr_i     (clr_i),
    .addr_o    (addr_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .abort_o   (abort_o),
    .overrun_o (overrun_o),
    .miso_o    (miso_o)
  );

  // reference: wire frame is A3 D3 A2 D2 A1 D1 A0 D0
  function automatic logic [63:0] pack_frame(input logic [31:0] a, input logic [31:0] d);
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      f[63 - 16*k -: 8] = a[31 - 8*k -: 8];
      f[55 - 16*k -: 8] = d[31 - 8*k -: 8];
    end
    return f;
  endfunction

  // scoreboard: every accepted handshake must match the oldest expected pair
  always @(negedge clk) begin
    logic [63:0] exp;
    if (abort_o) abort_cyc++;
    if (overrun_o) ovr_cyc++;
    if (nrst && valid_o && ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL handshake: unexpected word addr=%h data=%h, need none", addr_o, data_o);
      end else begin
        exp = exp_q.pop_front();
        if ({addr_o, data_o} !== exp) begin
          errors++;
          $display("FAIL handshake: got addr=%h data=%h, need addr=%h data=%h",
                   addr_o, data_o, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      ready_i = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cs_low();
    cs_n_i = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    tick(4);
    cs_n_i = 1'b1;
    tick(8);
  endtask

  task automatic clock_bit(input logic b);
    mosi_i = b;
    tick(4);
    sclk_i = 1'b1;
    tick(4);
    sclk_i = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f, input int nbits);
    cs_low();
    for (int i = 0; i < nbits; i++)
      clock_bit((i < 64) ? f[63 - i] : 1'($urandom_range(0, 1)));
    cs_high();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d words still expected, need 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // tests
  task automatic test_reset();
    nrst = 1'b0;
    tick(3);
    checks++;
    if ({addr_o, data_o, valid_o, busy_o, abort_o, overrun_o, miso_o} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %h/%h v%b b%b a%b o%b m%b, need all 0",
               addr_o, data_o, valid_o, busy_o, abort_o, overrun_o, miso_o);
    end
    nrst = 1'b1;
    tick(6);
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset idle: got valid=%b busy=%b, need 0/0", valid_o, busy_o);
    end
  endtask

  task automatic test_single();
    logic [63:0] f;
    f = 64'h12AA34BB56CC78DD;
    ready_i = 1'b1;
    exp_q.push_back({32'h12345678, 32'hAABBCCDD});
    cs_low();
    for (int i = 0; i < 10; i++) clock_bit(f[63 - i]);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single busy: got %b, need 1", busy_o);
    end
    for (int i = 10; i < 64; i++) clock_bit(f[63 - i]);
    cs_high();
    wait_drain("single");
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single valid_after: got %b, need 0", valid_o);
    end
  endtask

  task automatic test_abort();
    int a0;
    ready_i = 1'b1;
    a0 = abort_cyc;
    send_frame({$urandom, $urandom}, 23);
    checks++;
    if (abort_cyc - a0 != 1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_23 pulse: got %0d cycles valid=%b, need 1 cycle valid=0",
               abort_cyc - a0, valid_o);
    end
    a0 = abort_cyc;
    send_frame('0, 0);
    checks++;
    if (abort_cyc - a0 != 1) begin
      errors++;
      $display("FAIL abort_zero pulse: got %0d cycles, need 1", abort_cyc - a0);
    end
    exp_q.push_back({32'h00000001, 32'hFFFFFFFF});
    send_frame(pack_frame(32'h00000001, 32'hFFFFFFFF), 64);
    wait_drain("abort_next");
  endtask

  task automatic test_extra_clocks();
    logic [31:0] a, d;
    logic [63:0] f;
    int a0;
    a = $urandom;
    d = $urandom;
    f = pack_frame(a, d);
    ready_i = 1'b1;
    a0 = abort_cyc;
    exp_q.push_back({a, d});
    cs_low();
    for (int i = 0; i < 64; i++) clock_bit(f[63 - i]);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL extra busy_after_64: got %b, need 0", busy_o);
    end
    for (int i = 0; i < 6; i++) clock_bit(1'($urandom_range(0, 1)));
    cs_high();
    wait_drain("extra");
    checks++;
    if (abort_cyc != a0) begin
      errors++;
      $display("FAIL extra no_abort: got %0d abort cycles, need 0", abort_cyc - a0);
    end
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b1;
    cs_low();
    for (int i = 0; i < 40; i++) clock_bit(1'($urandom_range(0, 1)));
    nrst = 1'b0;
    cs_n_i = 1'b1;
    mosi_i = 1'b0;
    tick(2);
    checks++;
    if ({addr_o, data_o, valid_o, busy_o, abort_o, overrun_o, miso_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %h/%h v%b b%b a%b o%b m%b, need all 0",
               addr_o, data_o, valid_o, busy_o, abort_o, overrun_o, miso_o);
    end
    nrst = 1'b1;
    tick(4);
    exp_q.push_back({32'hDEADBEEF, 32'h0BADF00D});
    send_frame(pack_frame(32'hDEADBEEF, 32'h0BADF00D), 64);
    wait_drain("reset_mid");
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, d1, a2, d2;
    a1 = $urandom; d1 = $urandom;
    a2 = $urandom; d2 = $urandom;
    ready_i = 1'b0;
    send_frame(pack_frame(a1, d1), 64);
    send_frame(pack_frame(a2, d2), 64);
    checks++;
    if (valid_o !== 1'b1 || addr_o !== a1 || data_o !== d1 || overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL backpressure hold: got v%b %h/%h ovr%b, need v1 %h/%h ovr1",
               valid_o, addr_o, data_o, overrun_o, a1, d1);
    end
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    tick(1);
    checks++;
    if (overrun_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL backpressure clear: got ovr=%b valid=%b, need 0/1", overrun_o, valid_o);
    end
    clr_i = 1'b1;
    ovr_cyc = 0;
    send_frame({$urandom, $urandom}, 64);
    clr_i = 1'b0;
    checks++;
    if (ovr_cyc != 1) begin
      errors++;
      $display("FAIL set_wins overrun: got %0d high cycles, need 1", ovr_cyc);
    end
    checks++;
    if (addr_o !== a1 || data_o !== d1) begin
      errors++;
      $display("FAIL backpressure stable: got %h/%h, need %h/%h", addr_o, data_o, a1, d1);
    end
    exp_q.push_back({a1, d1});
    ready_i = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_random();
    int exp_aborts, a0;
    logic [31:0] a, d;
    exp_aborts = 0;
    a0 = abort_cyc;
    rand_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        exp_aborts++;
        send_frame(pack_frame(a, d), $urandom_range(0, 63));
      end else begin
        exp_q.push_back({a, d});
        send_frame(pack_frame(a, d), 64 + $urandom_range(0, 3));
      end
    end
    wait_drain("random");
    rand_ready = 1'b0;
    tick(2);
    ready_i = 1'b1;
    checks++;
    if (abort_cyc - a0 != exp_aborts || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL random aborts: got %0d ovr=%b, need %0d ovr=0",
               abort_cyc - a0, overrun_o, exp_aborts);
    end
  endtask

`ifdef T07_SPIRX_MISO_EN
  task automatic test_echo();
    logic [63:0] got;
    ready_i = 1'b1;
    exp_q.push_back({32'h12345678, 32'hAABBCCDD});
    send_frame(pack_frame(32'h12345678, 32'hAABBCCDD), 64);
    wait_drain("echo_load");
    exp_q.push_back({32'h0, 32'h0});
    cs_low();
    for (int i = 0; i < 64; i++) begin
      got[63 - i] = miso_o;
      clock_bit(1'b0);
    end
    cs_high();
    wait_drain("echo_frame");
    checks++;
    if (got !== 64'h12AA34BB56CC78DD) begin
      errors++;
      $display("FAIL echo stream: got %h, need 12aa34bb56cc78dd", got);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_abort();
    test_extra_clocks();
    test_reset_mid();
    test_backpressure();
    test_random();
`ifdef T07_SPIRX_MISO_EN
    test_echo();
`endif
    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t07_spi_frame_rx.md
Name: t07_spi_frame_rx

Overview:
- SPI target that receives the 64-bit interleaved address/data frames produced by the team's SPI TFT transmitter (chipSelect / bitData / sclk).
- Synchronises the three SPI pins into the system clock domain and samples data on sclk rising edges, MSB first.
- De-interleaves each frame back into a 32-bit address and a 32-bit data word, and hands the pair to the consumer over a valid/ready handshake.
- Used as the on-chip loopback checker for the display path and as the bench model for the TFT link.

Parameters:
- FRAME_BITS, 64, bits per frame; must be a multiple of 16.
- SYNC_STAGES, 2, flip-flop stages per synchroniser on cs_n_i, sclk_i and mosi_i; minimum 2.

Ports:
- clk  input  1  system clock; must run at least 4x the sclk frequency.
- nrst  input  1  asynchronous, active-low reset.
- cs_n_i  input  1  SPI chip select, active low (driven by the transmitter's chipSelect).
- sclk_i  input  1  SPI clock.
- mosi_i  input  1  SPI serial data (driven by the transmitter's bitData).
- ready_i  input  1  consumer accepts the held word.
- clr_i  input  1  clears the sticky overrun_o flag.
- addr_o  output  32  received address.
- data_o  output  32  received data.
- valid_o  output  1  addr_o and data_o hold an unconsumed frame.
- busy_o  output  1  a frame is in progress (state is SHIFT).
- abort_o  output  1  one-cycle pulse when a frame is cut short.
- overrun_o  output  1  sticky flag: a completed frame was dropped.
- miso_o  output  1  echo output; see Optional Feature.

Behaviour:
- Reset: all outputs are 0, state is IDLE, counter is 0, shift register is 0, synchroniser stages are 0 except the cs_n stages, which reset to 1.
- Edge detection:
  - Rise event = synchronised sclk was 0 in the previous cycle and is 1 now.
  - Fall event = synchronised sclk was 1 in the previous cycle and is 0 now.
  - mosi is sampled from its own synchroniser on the rise event. All three pins use equal synchroniser depth, so they stay aligned.
- FSM states: IDLE, SHIFT, WAIT_CS.
  - IDLE: when synchronised cs_n is 0, clear the counter and go to SHIFT. Edges while cs_n is high are ignored.
  - SHIFT: on each rise event, shift = {shift[62:0], mosi} and increment the counter (7 bits).
    - When the counter reaches 64, go to WAIT_CS and issue the frame-complete strobe in the same cycle.
    - If cs_n rises while the counter is below 64: pulse abort_o, discard the partial frame, go to IDLE. A frame that is exactly 0 bits long also pulses abort_o.
  - WAIT_CS: further rise events are ignored. cs_n high returns the FSM to IDLE.
- Frame layout (bit 63 first), rebuilt in parallel: addr = {f[63:56], f[47:40], f[31:24], f[15:8]} and data = {f[55:48], f[39:32], f[23:16], f[7:0]}.
- Latency: addr_o, data_o and valid_o update on the clk edge after the edge on which bit 64 is registered.
- Handshake:
  - valid_o stays high until a cycle in which both valid_o and ready_i are 1; it falls on the following edge.
  - addr_o and data_o are stable while valid_o is high.
  - Completion when valid_o is 0: load the new frame and set valid_o to 1.
  - Completion while valid_o and ready_i are both 1 in the same cycle: load the new frame, keep valid_o at 1, no overrun.
  - Completion while valid_o is 1 and ready_i is 0: drop the new frame, keep the old one, set overrun_o.
- overrun_o is cleared by clr_i. If clr_i and an overrun occur in the same cycle, set wins.
- busy_o is 1 exactly while the state is SHIFT.
- An asynchronous reset in the middle of a frame discards everything. The next frame is accepted only after cs_n has been seen high and then low again.

Optional Feature:
- Macro: T07_SPIRX_MISO_EN.
- When defined:
  - On the cs_n falling edge, the last accepted frame (re-interleaved) is loaded into a transmit shift register.
  - Each fall event drives miso_o with the next bit, MSB first. miso_o holds bit 63 from the start of the frame.
  - When valid_o was never set, the echo is all zeros.
- When not defined: miso_o is tied to 0 and no transmit register exists.

Decomposition:
- Package t07_spi_pkg:
  - state enum for IDLE / SHIFT / WAIT_CS (2-bit);
  - FRAME_BITS default;
  - de-interleave and interleave functions, shared with the transmitter.
- Sub-module t07_sync_edge: an N-stage synchroniser plus rise/fall detector, instantiated for sclk. cs_n and mosi use the synchroniser path only.

Test Plan:
- Single frame: address 0x12345678 and data 0xAABBCCDD sent as 0x12AA34BB56CC78DD with ready_i held at 1 -> valid_o pulses; addr_o = 0x12345678, data_o = 0xAABBCCDD.
- Backpressure: two frames with ready_i at 0 throughout -> first frame is held, overrun_o = 1, second frame is lost. Then clr_i -> overrun_o = 0.
- Abort: cs_n rises after 23 bits -> abort_o pulses for one cycle, valid_o stays 0. The next full frame, address 0x00000001 with data 0xFFFFFFFF, is received correctly.
- Extra clocks: 70 sclk pulses in one frame -> only the first 64 bits are used, no abort, busy_o drops after bit 64.
- Reset mid-frame: nrst is asserted after 40 bits, released, then a full frame 0xDEADBEEF / 0x0BADF00D is sent -> all outputs read 0 during reset, and the new frame is received exactly.
- Echo (only with T07_SPIRX_MISO_EN): after receiving 0x12345678 / 0xAABBCCDD, a new frame's miso_o stream equals 0x12AA34BB56CC78DD.
